softmax_sum_ctrl: RTL and testbench
===================================

SOFTMAX_SUM_CTRL -- requirements
Module: softmax_sum_ctrl

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, meaning lanes per input beat (power of 2, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning lane and sum width in bits.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, meaning width of the row-length (beat count) field.
REQ-004 SHALL use one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin a row; sampled only in IDLE.
REQ-007 cfg_len  input  LEN_WIDTH  beats in the row; sampled with start.
REQ-008 soft_clr  input  1  synchronous abort to IDLE.
REQ-009 in_valid  input  1  beat valid.
REQ-010 in_data  input  NUM_LANES*DATA_WIDTH  packed lanes, lane i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-011 in_ready  output  1  beat accepted when in_valid and in_ready are both high.
REQ-012 out_valid  output  1  row sum valid.
REQ-013 out_sum  output  DATA_WIDTH  row sum.
REQ-014 out_ready  input  1  consumer accepts out_sum.
REQ-015 busy  output  1  high in ACCUM or DONE.
REQ-016 err_zero_len  output  1  one-cycle pulse, start with cfg_len==0.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-018 IDLE: on start with cfg_len!=0, latch cfg_len, clear acc and beat counter, go to ACCUM next cycle.
REQ-019 IDLE: on start with cfg_len==0, pulse err_zero_len for exactly one cycle and stay in IDLE.
REQ-020 in_ready SHALL be 1 only in ACCUM; in IDLE and DONE in_valid is ignored.
REQ-021 Per accepted beat: acc <= acc + (sum of all NUM_LANES lanes), all arithmetic modulo 2^DATA_WIDTH, unsigned, with no saturation.
REQ-022 Beat counter SHALL increment per accepted beat; the beat where counter == latched_len-1 is the last beat.
REQ-023 On the last beat accepted, out_sum SHALL be registered with the final acc, and the FSM SHALL enter DONE with out_valid=1 the next cycle (latency 1 cycle from last beat).
REQ-024 Cycles with in_valid=0 in ACCUM SHALL leave acc and counter unchanged (bubbles allowed).
REQ-025 DONE: out_valid and out_sum SHALL hold stable until out_ready=1; on that cycle go to IDLE, out_valid=0 next cycle.
REQ-026 start while busy=1 SHALL be ignored; cfg_len changes while busy have no effect.
REQ-027 soft_clr SHALL take priority over all other inputs: next state is IDLE, out_valid=0, acc, counter and out_sum cleared, and no err pulse.
REQ-028 start and soft_clr in the same IDLE cycle: soft_clr wins and the row does not start.
REQ-029 In IDLE, start and out_ready in the same cycle SHALL never conflict (out_valid is 0 in IDLE).

Reset
REQ-030 On rst_n low, SHALL immediately force state=IDLE, acc=0, counter=0, out_sum=0, out_valid=0, in_ready=0, busy=0, err_zero_len=0.
REQ-031 Reset asserted mid-row SHALL discard the partial sum; no out_valid follows release.
REQ-032 After reset release, the first start is honoured on the first rising edge.

Structure
REQ-033 FSM state encoding SHALL live in the shared softmax package as a localparam/typedef set (ST_IDLE, ST_ACCUM, ST_DONE).
REQ-034 Default lane count and data width SHALL come from the shared package constants.
REQ-035 SHALL instantiate exactly one combinational adder-tree sub-module, sum, with NUM_INPUTS=NUM_LANES and DATA_WIDTH=DATA_WIDTH, fed directly by in_data.
REQ-036 All state elements SHALL be in one always block per register group; no latches.

Verification
REQ-037 Use NUM_LANES=4, DATA_WIDTH=16, len=3, beats {1,2,3,4},{5,6,7,8},{9,10,11,12} back-to-back -> out_sum=78, out_valid one cycle after third beat.
REQ-038 Same row with in_valid gaps of 2 cycles and out_ready held low 5 cycles -> out_sum=78 held stable 5 cycles; in_ready=0 in DONE.
REQ-039 Start with cfg_len=0 -> err_zero_len high exactly one cycle, busy stays 0, in_ready stays 0.
REQ-040 len=2, all lanes 0x4000 -> out_sum=0x0000 (wrap-around).
REQ-041 soft_clr after 1 of 3 beats, then new row len=1 beat {1,1,1,1} -> out_sum=4 with no stale contribution; start pulsed during ACCUM ignored.
REQ-042 rst_n asserted mid-row asynchronously -> all outputs 0 within the same cycle; no out_valid after release.

Source files
------------

// File: rtl/softmax_sum_ctrl_pkg.sv
// Shared constants and FSM encoding for the softmax row-sum controller.
package softmax_sum_ctrl_pkg;

    localparam int DEF_NUM_LANES  = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_LEN_WIDTH  = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/softmax_sum_ctrl_sum.sv
// Combinational adder tree: sums NUM_INPUTS packed lanes modulo 2^DATA_WIDTH.
module softmax_sum_ctrl_sum
    import softmax_sum_ctrl_pkg::*;
#(
    parameter int NUM_INPUTS = DEF_NUM_LANES,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]            sum
);

    // Pairwise reduction, halving the active width each level.
    always_comb begin
        logic [DATA_WIDTH-1:0] level [NUM_INPUTS];
        for (int i = 0; i < NUM_INPUTS; i++) begin
            level[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int w = NUM_INPUTS / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                level[i] = level[2*i] + level[2*i+1];
            end
        end
        sum = level[0];
    end

endmodule

// File: rtl/softmax_sum_ctrl.sv
// Accumulates a row of multi-lane beats into one sum and hands it to a consumer.
module softmax_sum_ctrl
    import softmax_sum_ctrl_pkg::*;
#(
    parameter int NUM_LANES  = DEF_NUM_LANES,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [LEN_WIDTH-1:0]            cfg_len,
    input  logic                            soft_clr,
    input  logic                            in_valid,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
    output logic                            in_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_sum,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            err_zero_len
);

    state_t                state;
    logic [DATA_WIDTH-1:0] acc;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] lane_sum;
    logic [DATA_WIDTH-1:0] acc_next;
    logic                  row_start;
    logic                  beat_fire;
    logic                  last_beat;

    softmax_sum_ctrl_sum #(
        .NUM_INPUTS (NUM_LANES),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sum (
        .in_data (in_data),
        .sum     (lane_sum)
    );

    // Handshake outputs decode straight from state so reset clears them at once.
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    assign row_start = (state == ST_IDLE) && start && (cfg_len != '0);
    assign beat_fire = in_ready && in_valid;
    assign last_beat = (cnt == len_q - LEN_WIDTH'(1));
    assign acc_next  = acc + lane_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (soft_clr) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (row_start) state <= ST_ACCUM;
                ST_ACCUM: if (beat_fire && last_beat) state <= ST_DONE;
                ST_DONE:  if (out_ready) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
        end else if (soft_clr) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
        end else if (row_start) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= cfg_len;
        end else if (beat_fire) begin
            acc   <= acc_next;
            cnt   <= cnt + 1'b1;
        end
    end

    // The final beat's contribution is folded in here rather than waiting on acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum <= '0;
        end else if (soft_clr) begin
            out_sum <= '0;
        end else if (beat_fire && last_beat) begin
            out_sum <= acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_zero_len <= 1'b0;
        end else begin
            err_zero_len <= !soft_clr && (state == ST_IDLE) && start && (cfg_len == '0);
        end
    end

endmodule

// File: tb/tb_softmax_sum_ctrl.sv
// Randomized and directed bench for softmax_sum_ctrl against a plain-arithmetic row-sum model.
module tb_softmax_sum_ctrl;

    localparam int NL = 4;
    localparam int DW = 16;
    localparam int LW = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [LW-1:0]     cfg_len;
    logic              soft_clr;
    logic              in_valid;
    logic [NL*DW-1:0]  in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_sum;
    logic              out_ready;
    logic              busy;
    logic              err_zero_len;

    int checks = 0;
    int errors = 0;
    logic [NL*DW-1:0] beats [16];

    softmax_sum_ctrl #(
        .NUM_LANES  (NL),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_len      (cfg_len),
        .soft_clr     (soft_clr),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_sum      (out_sum),
        .out_ready    (out_ready),
        .busy         (busy),
        .err_zero_len (err_zero_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: every lane of every beat added as integers, then reduced mod 2^16.
    function automatic int rowSum(input int len);
        int s = 0;
        for (int b = 0; b < len; b++)
            for (int l = 0; l < NL; l++)
                s += int'(beats[b][l*DW +: DW]);
        return s % 65536;
    endfunction

    function automatic logic [NL*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic startRow(input int len);
        cfg_len = LW'(len);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        cfg_len = LW'($urandom);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic applyStimulus(input int len, input int gap);
        for (int b = 0; b < len; b++) begin
            in_valid = 1'b1;
            in_data  = beats[b];
            checkOutput("in_ready_accum", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            if (b < len - 1) begin
                checkOutput("no_early_valid", 32'(out_valid), 32'd0);
                repeat (gap) tick();
            end
        end
        checkOutput("out_valid_lat1", 32'(out_valid), 32'd1);
        checkOutput("out_sum", 32'(out_sum), 32'(rowSum(len)));
    endtask

    task automatic drainOutput(input int hold, input int expSum);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            tick();
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_sum", 32'(out_sum), 32'(expSum));
            checkOutput("done_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("valid_drop", 32'(out_valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; soft_clr = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err_zero_len), 32'd0);
        checkOutput("rst_sum", 32'(out_sum), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic row of three back-to-back beats.
        beats[0] = pack4(1, 2, 3, 4);
        beats[1] = pack4(5, 6, 7, 8);
        beats[2] = pack4(9, 10, 11, 12);
        startRow(3);
        applyStimulus(3, 0);
        checkOutput("sum78", 32'(out_sum), 32'd78);
        drainOutput(0, 78);

        // Same row with bubbles and a stalled consumer.
        startRow(3);
        applyStimulus(3, 2);
        drainOutput(5, 78);

        // Zero-length start.
        cfg_len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("err_pulse", 32'(err_zero_len), 32'd1);
        checkOutput("err_busy", 32'(busy), 32'd0);
        checkOutput("err_in_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("err_one_cycle", 32'(err_zero_len), 32'd0);
        checkOutput("err_still_idle", 32'(busy), 32'd0);

        // Wrap-around.
        beats[0] = pack4(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        beats[1] = beats[0];
        startRow(2);
        applyStimulus(2, 0);
        checkOutput("wrap_zero", 32'(out_sum), 32'd0);
        drainOutput(1, 0);

        // Abort mid-row, with a stray start during ACCUM.
        beats[0] = pack4(100, 200, 300, 400);
        startRow(3);
        in_valid = 1'b1; in_data = beats[0];
        tick();
        in_valid = 1'b0;
        cfg_len = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_ignored_busy", 32'(busy), 32'd1);
        checkOutput("start_ignored_rdy", 32'(in_ready), 32'd1);
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        checkOutput("clr_busy", 32'(busy), 32'd0);
        checkOutput("clr_sum", 32'(out_sum), 32'd0);
        checkOutput("clr_no_err", 32'(err_zero_len), 32'd0);
        beats[0] = pack4(1, 1, 1, 1);
        startRow(1);
        applyStimulus(1, 0);
        checkOutput("sum4_no_stale", 32'(out_sum), 32'd4);
        drainOutput(0, 4);

        // soft_clr beats start in the same IDLE cycle.
        cfg_len = 8'd2; start = 1'b1; soft_clr = 1'b1;
        tick();
        start = 1'b0; soft_clr = 1'b0;
        checkOutput("clr_wins_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-row.
        beats[0] = pack4(7, 7, 7, 7);
        startRow(3);
        in_valid = 1'b1; in_data = beats[0];
        tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_sum", 32'(out_sum), 32'd0);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("arst_no_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;

        // Start honoured on the first edge after release.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        startRow(1);
        applyStimulus(1, 0);
        drainOutput(0, 28);

        // Randomized rows.
        for (int r = 0; r < 25; r++) begin
            int len;
            len = int'($urandom_range(1, 8));
            for (int b = 0; b < len; b++) beats[b] = {$urandom, $urandom};
            startRow(len);
            applyStimulus(len, int'($urandom_range(0, 2)));
            drainOutput(int'($urandom_range(0, 3)), rowSum(len));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
